// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encoding, default timing and counter sizing for button_events
package button_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHORT = 2'd1;
    localparam state_t LONG  = 2'd2;

    // 0.5 s long-press threshold and 0.1 s repeat period at 12 MHz
    localparam int LONG_CYCLES_DEFAULT   = 6_000_000;
    localparam int REPEAT_CYCLES_DEFAULT = 1_200_000;

    function automatic int cnt_width(input int long_cycles, input int repeat_cycles);
        int m;
        m = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/button_events_if.sv
// rtl/button_events_if.sv - debounced level in, one-cycle button event pulses out
interface button_events_if;

    logic level;
    logic press;
    logic release_pulse;
    logic long_press;
    logic repeat_pulse;
    logic held;

    modport master (
        output level,
        input  press,
        input  release_pulse,
        input  long_press,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  level,
        output press,
        output release_pulse,
        output long_press,
        output repeat_pulse,
        output held
    );

endinterface

// File: rtl/button_events.sv
// rtl/button_events.sv - turns a debounced button level into press/release/long-press/repeat pulses
module button_events
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = LONG_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    button_events_if.slave  btn
);

    localparam int               CNT_W       = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic press_q, release_q, long_q, repeat_q, held_q;
    logic press_d, release_d, long_d, repeat_d, held_d;

    // Any low sample, and the unused encoding, fall back to IDLE with a cleared count
    always_comb begin
        state_d = IDLE;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (btn.level) begin
                    state_d = SHORT;
                    cnt_d   = CNT_W'(1);
                end
            end
            SHORT: begin
                if (btn.level) begin
                    if (cnt_q == LONG_LAST) begin
                        state_d = LONG;
                        cnt_d   = '0;
                    end else begin
                        state_d = SHORT;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            LONG: begin
                if (btn.level) begin
                    state_d = LONG;
                    cnt_d   = (cnt_q == REPEAT_LAST) ? '0 : cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Release takes priority over a count that completes on the same sample
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                press_d = btn.level;
            end
            SHORT: begin
                release_d = !btn.level;
                long_d    = btn.level && (cnt_q == LONG_LAST);
            end
            LONG: begin
                release_d = !btn.level;
                repeat_d  = btn.level && (cnt_q == REPEAT_LAST);
            end
            default: begin
                press_d = 1'b0;
            end
        endcase
        held_d = (state_d == SHORT) || (state_d == LONG);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign btn.press         = press_q;
    assign btn.release_pulse = release_q;
    assign btn.long_press    = long_q;
    assign btn.repeat_pulse  = repeat_q;
    assign btn.held          = held_q;

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - self-checking bench for button_events with a run-length reference model
module tb_button_events;

    localparam int L = 8;
    localparam int R = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic cmp_en = 1'b0;

    button_events_if bif ();

    button_events #(
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (R)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: run = number of consecutive high samples seen so far
    int   run = 0;
    logic e_press = 1'b0, e_rel = 1'b0, e_long = 1'b0, e_rep = 1'b0, e_held = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            run = 0;
            e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0; e_held = 1'b0;
        end else begin
            e_press = bif.level && (run == 0);
            e_rel   = !bif.level && (run > 0);
            e_long  = bif.level && (run + 1 == L);
            e_rep   = bif.level && (run + 1 > L) && (((run + 1 - L) % R) == 0);
            e_held  = bif.level;
            run     = bif.level ? run + 1 : 0;
        end
    end

    int cyc = 0;
    int n_press, n_rel, n_long, n_rep, n_held;
    int press_cyc, rel_cyc, long_at, first_rep_at;

    task automatic clear_counts();
        n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; n_held = 0;
        press_cyc = -1; rel_cyc = -1; long_at = -1; first_rep_at = -1;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (cmp_en) begin
            check("press",      int'(bif.press),         int'(e_press));
            check("release",    int'(bif.release_pulse), int'(e_rel));
            check("long_press", int'(bif.long_press),    int'(e_long));
            check("repeat",     int'(bif.repeat_pulse),  int'(e_rep));
            check("held",       int'(bif.held),          int'(e_held));
        end
        if (bif.press === 1'b1) begin n_press++; press_cyc = cyc; end
        if (bif.release_pulse === 1'b1) begin n_rel++; rel_cyc = cyc; end
        if (bif.long_press === 1'b1) begin n_long++; long_at = cyc - press_cyc; end
        if (bif.repeat_pulse === 1'b1) begin
            if (n_rep == 0) first_rep_at = cyc - press_cyc;
            n_rep++;
        end
        if (bif.held === 1'b1) n_held++;
    end

    task automatic step(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            bif.level = v;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        bif.level = 1'b0;
        clear_counts();
        @(negedge clk);
        #1;
        check("reset_held",  int'(bif.held),  0);
        check("reset_press", int'(bif.press), 0);
        step(1'b0, 2);
        reset = 1'b0;
        cmp_en = 1'b1;

        // idle after reset
        clear_counts();
        step(1'b0, 20);
        check("idle_events", n_press + n_rel + n_long + n_rep, 0);
        check("idle_held",   n_held, 0);

        // short press of 3 samples
        clear_counts();
        step(1'b1, 3);
        step(1'b0, 4);
        check("short_press",   n_press, 1);
        check("short_held",    n_held,  3);
        check("short_release", n_rel,   1);
        check("short_long",    n_long,  0);

        // held for 20 samples
        clear_counts();
        step(1'b1, 20);
        step(1'b0, 4);
        check("hold_press",     n_press,      1);
        check("hold_long",      n_long,       1);
        check("hold_long_at",   long_at,      7);
        check("hold_repeats",   n_rep,        3);
        check("hold_first_rep", first_rep_at, 11);
        check("hold_release",   n_rel,        1);

        // release on the sample that would complete the long count
        clear_counts();
        step(1'b1, 7);
        step(1'b0, 3);
        check("edge_long",    n_long, 0);
        check("edge_release", n_rel,  1);
        check("edge_held",    n_held, 7);
        check("edge_idle",    int'(bif.held), 0);

        // release on the sample that would complete the first repeat
        clear_counts();
        step(1'b1, 11);
        step(1'b0, 3);
        check("redge_long",    n_long, 1);
        check("redge_repeat",  n_rep,  0);
        check("redge_release", n_rel,  1);

        // asynchronous reset mid-press
        clear_counts();
        step(1'b1, 10);
        #2 reset = 1'b1;
        #1;
        check("async_held",  int'(bif.held), 0);
        check("async_pulse", int'(bif.press | bif.release_pulse | bif.long_press | bif.repeat_pulse), 0);
        step(1'b1, 2);
        check("async_no_release", n_rel, 0);
        reset = 1'b0;
        clear_counts();
        step(1'b1, 1);
        check("async_repress", n_press, 1);
        step(1'b0, 3);
        check("async_release", n_rel, 1);

        // one-sample glitch
        clear_counts();
        step(1'b1, 1);
        step(1'b0, 4);
        check("glitch_press",   n_press, 1);
        check("glitch_release", n_rel,   1);
        check("glitch_held",    n_held,  1);
        check("glitch_gap",     rel_cyc - press_cyc, 1);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_events.md
# button_events

Converts the debounced, synchronous button level into one-cycle event pulses for the scope's control logic: press, release, long-press and auto-repeat while held. It sits directly downstream of the button debounce filter, one instance per button. Mode and trigger-level logic consume only these pulses and never sample the raw level.

## Interface
- `LONG_CYCLES`, default 6_000_000: samples the level must stay high, counting the press sample as sample 1, before `long_press` fires (0.5 s at 12 MHz). Must be ≥ 2.
- `REPEAT_CYCLES`, default 1_200_000: period in samples between `repeat` pulses after `long_press`. Must be ≥ 1.
- `clk` in 1: system clock. The block samples `level` on every rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `level` in 1: debounced button level, already synchronous to `clk`. 1 means pressed.
- `press` out 1: one-cycle pulse on a 0→1 transition of `level`.
- `release` out 1: one-cycle pulse on a 1→0 transition of `level`.
- `long_press` out 1: one-cycle pulse, at most once per press.
- `repeat` out 1: one-cycle pulse, periodic after `long_press` while the button stays held.
- `held` out 1: high while the FSM is in any pressed state.

## Operation
- FSM states: IDLE, SHORT, LONG.
- Counter `cnt` has width clog2(max(LONG_CYCLES, REPEAT_CYCLES)).
- IDLE with `level`=1: go to SHORT, `cnt`←1, `press`←1.
- SHORT with `level`=1:
  - If `cnt` = LONG_CYCLES-1: go to LONG, `cnt`←0, `long_press`←1.
  - Otherwise `cnt`←`cnt`+1.
- LONG with `level`=1:
  - If `cnt` = REPEAT_CYCLES-1: `cnt`←0, `repeat`←1.
  - Otherwise `cnt`←`cnt`+1.
- SHORT or LONG with `level`=0: go to IDLE, `cnt`←0, `release`←1.
- IDLE with `level`=0: hold.
- All pulse outputs are registered and default to 0 every cycle.
- At most one of `press`, `release`, `long_press`, `repeat` is high in any cycle.
- `held` is registered: 1 in the cycle after a transition into SHORT, 0 in the cycle after a transition into IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, `cnt` 0. Reset applies immediately, without waiting for a clock edge.
- Reset asserted mid-press produces no `release` pulse.
- Latency: each pulse is visible in the cycle after the edge that sampled the causing `level` value.
- `level`=1 at the first edge after reset deasserts counts as a new press: `press` fires.
- `long_press` appears after the edge sampling the LONG_CYCLES-th consecutive high sample.
- `repeat` pulses follow the samples at LONG_CYCLES + n·REPEAT_CYCLES, n ≥ 1.
- Release on the same sample that would have completed the long or repeat count: release wins. Only `release` fires and the counter clears.
- REPEAT_CYCLES=1: `repeat` is high every cycle in LONG. This is the one allowed exception to single-cycle pulse width.
- There is no wrap-around: `cnt` is always cleared at its terminal value.
- A one-sample glitch of `level` produces `press` followed by `release` in consecutive cycles. This is legal; filtering is upstream.

## Structure
- Shared package/header `button_pkg`:
  - State encoding localparams: IDLE=2'd0, SHORT=2'd1, LONG=2'd2.
  - Default LONG_CYCLES and REPEAT_CYCLES values, so every button instance agrees.
- Single flat module with no sub-module.
- Counter and FSM live in one sequential process; next-state logic is in a combinational process.
- Unreachable state 2'd3 recovers to IDLE with all outputs 0.

## Test plan
All scenarios use LONG_CYCLES=8, REPEAT_CYCLES=4.
- Reset with `level`=0, then idle for 20 cycles -> all outputs stay 0.
- `level` high for 3 samples, then low -> `press` in cycle 1 after the rise, `held` high for 3 cycles, `release` once after the fall, no `long_press`.
- `level` high for 20 samples -> `press` once, `long_press` after sample 8, `repeat` after samples 12, 16 and 20, `release` after the fall.
- `level` falls exactly at sample 8 (7 high samples, then low) -> no `long_press`, `release` only, FSM back in IDLE.
- Assert `reset` asynchronously at sample 10 while held -> outputs go to 0 immediately with no `release`. With `level` still 1 at reset deassert, `press` fires at the first edge after deassert.
- Single-sample high glitch -> `press` then `release` on consecutive cycles, `held` high for exactly 1 cycle.
